// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one-at-a-time word fetches and
// hands instructions to the decoder through a one-entry output buffer.
module ifu_fetch #(
  parameter int unsigned        ADDR_W   = 64,
  parameter int unsigned        INST_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_err
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [INST_W-1:0] inst_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              inst_valid_q;
  logic              fetch_err_q;
  logic              req_fire;

  // Request only when the buffer is free this cycle; never depends on imem_req_ready.
  assign imem_req_valid = !rst && (state_q == S_REQ) && !fetch_err_q &&
                          (!inst_valid_q || inst_ready);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign fetch_err  = fetch_err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else if (redirect_valid) begin
      // Redirect wins: flush the buffer and mark any in-flight fetch as wrong-path.
      pc_q         <= redirect_pc;
      inst_valid_q <= 1'b0;
      if (redirect_pc[1:0] != 2'b00) begin
        fetch_err_q <= 1'b1;
      end
      case (state_q)
        S_REQ:          state_q <= req_fire ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_q <= imem_rsp_valid ? S_REQ : S_DROP;
        default:        state_q <= S_REQ;
      endcase
    end else begin
      if (inst_valid_q && inst_ready) begin
        inst_valid_q <= 1'b0;
      end
      case (state_q)
        S_REQ: begin
          if (req_fire) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rsp_valid) begin
            inst_q       <= imem_rsp_data;
            inst_pc_q    <= pc_q;
            inst_valid_q <= 1'b1;
            pc_q         <= pc_q + ADDR_W'(4);
            state_q      <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rsp_valid) begin
            state_q <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: directed scenarios plus randomized traffic against a
// transaction-level model (fetch in flight / wrong-path flag / output buffer).
module tb_ifu_fetch;

  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned INST_W   = 32;
  localparam logic [63:0] RESET_PC = 64'h8000_0000;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              imem_req_valid;
  logic              imem_req_ready = 1'b0;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid = 1'b0;
  logic [INST_W-1:0] imem_rsp_data = '0;
  logic              redirect_valid = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              inst_valid;
  logic              inst_ready = 1'b0;
  logic [INST_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              fetch_err;

  always #5 clk = ~clk;

  ifu_fetch #(.ADDR_W(ADDR_W), .INST_W(INST_W), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .fetch_err      (fetch_err)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: PC, whether a fetch is outstanding and whether it is stale.
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_inst;
  bit          m_busy, m_wrong, m_bv, m_err, m_req;

  // Memory: single pending response with a countdown.
  bit          pend = 1'b0;
  int          pend_cnt = 0;
  logic [31:0] pend_data = '0;
  int          lat = 1;

  // Stimulus for the next cycle.
  bit          s_rst = 1'b1, s_mrdy = 1'b1, s_irdy = 1'b1, s_redir = 1'b0;
  logic [63:0] s_rpc = '0;

  logic [63:0] obs_req[$];
  logic [95:0] obs_del[$];

  function automatic void model_reset();
    m_pc = RESET_PC; m_ipc = '0; m_inst = '0;
    m_busy = 1'b0; m_wrong = 1'b0; m_bv = 1'b0; m_err = 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc_begin();
    @(negedge clk);
    rst            = s_rst;
    imem_req_ready = s_mrdy;
    inst_ready     = s_irdy;
    redirect_valid = s_redir;
    redirect_pc    = s_rpc;
    imem_rsp_valid = pend && (pend_cnt == 0);
    imem_rsp_data  = imem_rsp_valid ? pend_data : 32'($urandom());
    if (s_rst) model_reset();
    m_req = !s_rst && !m_busy && !m_err && (!m_bv || s_irdy);
    #1;
    chk("req_valid", 64'(imem_req_valid), 64'(m_req));
    chk("req_addr",  imem_req_addr, m_pc);
    chk("inst_valid", 64'(inst_valid), 64'(m_bv));
    chk("inst",      64'(inst), 64'(m_inst));
    chk("inst_pc",   inst_pc, m_ipc);
    chk("fetch_err", 64'(fetch_err), 64'(m_err));
    if (imem_req_valid && imem_req_ready) obs_req.push_back(imem_req_addr);
    if (inst_valid && inst_ready) obs_del.push_back({inst_pc, inst});
  endtask

  task automatic cyc_end();
    bit          hs, dlv, fired;
    logic [63:0] a;
    @(posedge clk);
    fired = imem_rsp_valid;
    hs    = m_req && s_mrdy;
    dlv   = m_bv && s_irdy;
    a     = m_pc;
    if (s_rst) begin
      model_reset();
    end else if (s_redir) begin
      m_pc = s_rpc;
      m_bv = 1'b0;
      if (s_rpc[1:0] != 2'b00) m_err = 1'b1;
      if (hs || (m_busy && !fired)) begin
        m_busy = 1'b1; m_wrong = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
    end else begin
      if (dlv) m_bv = 1'b0;
      if (m_busy && fired) begin
        if (!m_wrong) begin
          m_bv = 1'b1; m_ipc = m_pc; m_inst = m_pc[31:0] ^ 32'h13; m_pc = m_pc + 64'd4;
        end
        m_busy = 1'b0;
      end
      if (hs) begin
        m_busy = 1'b1; m_wrong = 1'b0;
      end
    end
    if (fired) pend = 1'b0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (hs && !s_rst) begin
      pend = 1'b1; pend_cnt = lat - 1; pend_data = a[31:0] ^ 32'h13;
    end
  endtask

  task automatic step();
    cyc_begin();
    cyc_end();
  endtask

  task automatic do_reset(input bit keep_pend);
    s_rst = 1'b1; s_redir = 1'b0;
    if (!keep_pend) pend = 1'b0;
    step();
    step();
    s_rst = 1'b0;
    obs_req.delete();
    obs_del.delete();
  endtask

  int n;

  initial begin
    model_reset();
    // Reset and sequential fetch with 1-cycle memory.
    s_rst = 1'b1; s_mrdy = 1'b1; s_irdy = 1'b1;
    step();
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_pc", imem_req_addr, 64'h8000_0000);
    s_rst = 1'b0; lat = 1;
    repeat (6) step();
    chk("seq_nreq", 64'(obs_req.size()), 64'd3);
    for (int i = 0; i < obs_req.size() && i < 3; i++)
      chk("seq_req", obs_req[i], 64'h8000_0000 + 64'(4 * i));
    chk("seq_ndel", 64'(obs_del.size()), 64'd2);
    if (obs_del.size() > 0) chk("seq_del0", 64'(obs_del[0]), 64'(96'h8000_0000_8000_0013));

    // Decoder backpressure.
    do_reset(1'b0);
    s_irdy = 1'b0;
    step(); step();
    repeat (5) begin
      cyc_begin();
      chk("bp_inst_pc", inst_pc, 64'h8000_0000);
      chk("bp_inst", 64'(inst), 64'h8000_0013);
      chk("bp_req_valid", 64'(imem_req_valid), 64'd0);
      cyc_end();
    end
    s_irdy = 1'b1;
    cyc_begin();
    chk("bp_resume_valid", 64'(imem_req_valid), 64'd1);
    chk("bp_resume_addr", imem_req_addr, 64'h8000_0004);
    cyc_end();

    // Redirect while waiting on a 3-cycle response.
    do_reset(1'b0);
    lat = 3;
    repeat (5) step();
    s_redir = 1'b1; s_rpc = 64'h8000_0100;
    step();
    s_redir = 1'b0;
    repeat (2) begin
      cyc_begin();
      chk("rw_inst_valid", 64'(inst_valid), 64'd0);
      chk("rw_req_valid", 64'(imem_req_valid), 64'd0);
      cyc_end();
    end
    cyc_begin();
    chk("rw_req_valid2", 64'(imem_req_valid), 64'd1);
    chk("rw_req_addr", imem_req_addr, 64'h8000_0100);
    cyc_end();

    // Redirect in the same cycle as the response.
    step(); step();
    s_redir = 1'b1; s_rpc = 64'h8000_0200;
    step();
    s_redir = 1'b0;
    cyc_begin();
    chk("rr_inst_valid", 64'(inst_valid), 64'd0);
    chk("rr_req_valid", 64'(imem_req_valid), 64'd1);
    chk("rr_req_addr", imem_req_addr, 64'h8000_0200);
    cyc_end();

    // Redirect while an instruction sits in the buffer and the decoder stalls.
    s_irdy = 1'b0;
    repeat (3) step();
    s_redir = 1'b1; s_rpc = 64'h8000_0300;
    cyc_begin();
    chk("rb_inst_valid", 64'(inst_valid), 64'd1);
    chk("rb_inst_pc", inst_pc, 64'h8000_0200);
    cyc_end();
    s_redir = 1'b0; s_irdy = 1'b1;
    cyc_begin();
    chk("rb_flushed", 64'(inst_valid), 64'd0);
    chk("rb_req_addr", imem_req_addr, 64'h8000_0300);
    cyc_end();
    step();
    n = 0;
    foreach (obs_del[i]) if (obs_del[i][95:32] == 64'h8000_0004 || obs_del[i][95:32] == 64'h8000_0200) n++;
    chk("wrong_path_delivered", 64'(n), 64'd0);

    // Misaligned redirect: sticky error, requests stop until reset.
    s_redir = 1'b1; s_rpc = 64'h8000_0102;
    step();
    s_redir = 1'b0;
    repeat (10) begin
      cyc_begin();
      chk("mis_err", 64'(fetch_err), 64'd1);
      chk("mis_req_valid", 64'(imem_req_valid), 64'd0);
      cyc_end();
    end
    s_rst = 1'b1;
    cyc_begin();
    chk("mis_err_cleared", 64'(fetch_err), 64'd0);
    cyc_end();
    s_rst = 1'b0;

    // Randomized traffic, including mid-run resets and PC wrap-around.
    for (int ep = 0; ep < 6; ep++) begin
      lat = int'($urandom_range(1, 4));
      do_reset(1'b1);
      for (int c = 0; c < 300; c++) begin
        s_mrdy  = ($urandom % 4) != 0;
        s_irdy  = ($urandom % 3) != 0;
        s_redir = ($urandom % 16) == 0;
        s_rst   = ($urandom % 150) == 0;
        if ($urandom % 8 == 0) s_rpc = 64'hFFFF_FFFF_FFFF_FFF8;
        else s_rpc = 64'h8000_0000 + 64'($urandom_range(0, 63) * 4);
        if (ep == 5 && c > 200 && ($urandom % 32) == 0) s_rpc[1:0] = 2'($urandom_range(1, 3));
        step();
      end
      s_rst = 1'b0; s_redir = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit: owns the architectural PC and supplies 32-bit instructions, with their PCs, to the instruction decoder through a valid/ready handshake. It issues word fetches to instruction memory over a request/response interface and allows one request in flight. It also holds one decoded-side output buffer. Taken jumps and branches from execute redirect the PC. Any in-flight or buffered wrong-path instruction is discarded.

## Interface
- `ADDR_W`, default 64: PC and fetch address width.
- `INST_W`, default 32: instruction width.
- `RESET_PC`, default 64'h8000_0000: PC value after reset.

- `clk`, input, 1: clock. All state updates on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `imem_req_valid`, output, 1: fetch request valid.
- `imem_req_ready`, input, 1: memory accepts the request this cycle.
- `imem_req_addr`, output, ADDR_W: fetch address. Equals the current PC.
- `imem_rsp_valid`, input, 1: response data valid. Always accepted, with no backpressure.
- `imem_rsp_data`, input, INST_W: fetched instruction word.
- `redirect_valid`, input, 1: taken jump or branch. Replaces the PC.
- `redirect_pc`, input, ADDR_W: redirect target.
- `inst_valid`, output, 1: output buffer holds an instruction.
- `inst_ready`, input, 1: the decoder takes the instruction this cycle.
- `inst`, output, INST_W: instruction to the decoder.
- `inst_pc`, output, ADDR_W: PC of `inst`.
- `fetch_err`, output, 1: sticky flag. Set when a redirect target is not 4-byte aligned.

## Operation
- **State machine.** States are REQ, WAIT and DROP. Registers are `pc`, the output buffer (`inst`, `inst_pc`, `inst_valid`) and `fetch_err`.
- **REQ state.**
  - `imem_req_valid` = 1 when the buffer will be free this cycle, i.e. `!inst_valid || inst_ready`. Otherwise it is 0.
  - `imem_req_addr` = `pc`.
  - On a request handshake, go to WAIT.
  - If `fetch_err` = 1, `imem_req_valid` is forced to 0 and the unit stalls in REQ until reset.
- **WAIT state.** On `imem_rsp_valid`:
  - Load the buffer with `inst` = `imem_rsp_data`, `inst_pc` = `pc`, `inst_valid` = 1.
  - `pc` <= `pc` + 4. Wrap modulo 2^ADDR_W with no carry-out.
  - Go to REQ.
- **DROP state.** On `imem_rsp_valid`, discard the data. The buffer and `pc` are unchanged. Go to REQ.
- **Output handshake.** When `inst_valid && inst_ready` and no load happens that cycle, `inst_valid` <= 0. `inst` and `inst_pc` hold their values until the next load.
- **Redirect.** Redirect has the highest priority and takes effect at the edge ending the cycle in which `redirect_valid` = 1.
  - `pc` <= `redirect_pc`.
  - `inst_valid` <= 0. This applies even if `inst_ready` = 1 the same cycle; that handshake still counts as delivered.
  - Next state by case:
    - REQ with a request handshake the same cycle: go to DROP.
    - REQ with no handshake: stay in REQ.
    - WAIT with no response the same cycle: go to DROP.
    - WAIT with a response the same cycle: discard the response, no buffer load, go to REQ.
    - DROP with no response: stay in DROP.
    - DROP with a response the same cycle: go to REQ.
  - If `redirect_pc[1:0]` != 0, set `fetch_err` <= 1. `pc` still updates.
- **Outstanding limit.** At most one request is in flight. No request is issued from WAIT or DROP.

## Timing
- **Reset values.**
  - State = REQ, `pc` = RESET_PC.
  - `imem_req_valid` = 0 while `rst` = 1.
  - `inst_valid` = 0, `inst` = 0, `inst_pc` = 0, `fetch_err` = 0.
- **First request.** `imem_req_valid` = 1 in the first cycle after `rst` deasserts.
- **Request output.** `imem_req_valid` and `imem_req_addr` are combinational from state, `pc` and buffer occupancy. `imem_req_valid` has no combinational path from `imem_req_ready`.
- **Latency.**
  - Response in cycle N gives `inst_valid` = 1 in cycle N+1.
  - The next request can issue in cycle N+1 if the decoder has `inst_ready` = 1.
  - Peak throughput is one instruction per 2 cycles with 1-cycle memory.
- **Redirect visibility.** A redirect in cycle N gives `inst_valid` = 0 in N+1. The first request at the target is in N+1 if the state is REQ at N+1.
- **Reset mid-operation.** Reset forces the reset values immediately (asynchronously). A response arriving after reset deasserts, with state = REQ, is ignored.

## Test plan
- **Reset and sequential fetch.**
  - Stimulus: release reset; memory has 1-cycle latency, ready = 1, data = addr[31:0] ^ 32'h13; decoder ready = 1.
  - Required: requests at 0x8000_0000, 0x8000_0004, 0x8000_0008. Outputs `inst_pc` 0x8000_0000/inst 0x8000_0013, and so on, one every 2 cycles.
- **Decoder backpressure.**
  - Stimulus: `inst_ready` = 0 for 5 cycles after the first instruction.
  - Required: `inst` and `inst_pc` stay stable at 0x8000_0000; `imem_req_valid` = 0 throughout. When ready rises, the next request, to 0x8000_0004, issues the same cycle.
- **Redirect in WAIT.**
  - Stimulus: memory latency 3. Redirect to 0x8000_0100 one cycle after the request to 0x8000_0004 is accepted.
  - Required: the 0x8000_0004 response is dropped, `inst_valid` stays 0, the next request address is 0x8000_0100.
- **Simultaneous redirect and response.**
  - Stimulus: redirect to 0x8000_0200 in the same cycle as the response.
  - Required: the response is not loaded, state = REQ, request to 0x8000_0200 the next cycle.
- **Redirect with buffered instruction and `inst_ready` = 0.**
  - Required: `inst_valid` = 0 the next cycle, and the buffered instruction is never delivered.
- **Misaligned redirect.**
  - Stimulus: redirect to 0x8000_0102.
  - Required: `fetch_err` = 1 the next cycle and stays 1; no further requests; cleared only by `rst`.
